// File: rtl/tcu_ctrl_write_ep_if.sv
// tcu_ctrl_write_ep_if
//   Groups the command side (start, EP index, image words, mask) and the
//   register-file write side (strobe, address, data, stall) of the TCU
//   endpoint write sequencer.
//   master : command FSM + register file (drives starts/image/stall)
//   slave  : the sequencer (drives strobe/addr/wdata/active/done)
interface tcu_ctrl_write_ep_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int EP_W   = 16
);
  // register-file write port
  logic              write_ep_reg_en_o;
  logic [ADDR_W-1:0] write_ep_reg_addr_o;
  logic [DATA_W-1:0] write_ep_reg_wdata_o;
  logic              write_ep_reg_stall_i;
  // command side
  logic [EP_W-1:0]   write_ep_epidx_i;
  logic [EP_W-1:0]   write_ep_ext_epidx_i;
  logic [DATA_W-1:0] write_ep_data_0_i;
  logic [DATA_W-1:0] write_ep_data_1_i;
  logic [DATA_W-1:0] write_ep_data_2_i;
  logic [2:0]        write_ep_mask_i;
  logic              write_ep_start_i;
  logic              write_ep_ext_start_i;
  logic              write_ep_active_o;
  logic              write_ep_done_o;

  modport master (
    input  write_ep_reg_en_o, write_ep_reg_addr_o, write_ep_reg_wdata_o,
           write_ep_active_o, write_ep_done_o,
    output write_ep_reg_stall_i, write_ep_epidx_i, write_ep_ext_epidx_i,
           write_ep_data_0_i, write_ep_data_1_i, write_ep_data_2_i,
           write_ep_mask_i, write_ep_start_i, write_ep_ext_start_i
  );

  modport slave (
    output write_ep_reg_en_o, write_ep_reg_addr_o, write_ep_reg_wdata_o,
           write_ep_active_o, write_ep_done_o,
    input  write_ep_reg_stall_i, write_ep_epidx_i, write_ep_ext_epidx_i,
           write_ep_data_0_i, write_ep_data_1_i, write_ep_data_2_i,
           write_ep_mask_i, write_ep_start_i, write_ep_ext_start_i
  );
endinterface

// File: rtl/tcu_ctrl_write_ep.sv
// tcu_ctrl_write_ep
//   Writes a 3-word endpoint image into the TCU register file, one word per
//   cycle, skipping words whose mask bit is clear and holding on stall.
//   Started from the unprivileged path (priority) or the external path.
// Ports:
//   clk_i          rising-edge clock
//   reset_i        synchronous active-high reset
//   ep             tcu_ctrl_write_ep_if.slave (command + register-file port)
//   write_ep_cnt_o completed-sequence counter, saturating (only when
//                  TCU_WRITE_EP_CNT_EN is defined)
// Optional feature macro: TCU_WRITE_EP_CNT_EN
// TCU_REG_DATA_SIZE must be 64 (image words are 64 bit).
module tcu_ctrl_write_ep #(
  parameter int          TCU_REG_ADDR_SIZE    = 32,
  parameter int          TCU_REG_DATA_SIZE    = 64,
  parameter int          TCU_EP_SIZE          = 16,
  parameter logic [31:0] TCU_REGADDR_EP_START = 32'h0000_0040,
  parameter int          TCU_EP_REG_SIZE      = 24
) (
  input  logic clk_i,
  input  logic reset_i,
  tcu_ctrl_write_ep_if.slave ep
`ifdef TCU_WRITE_EP_CNT_EN
  ,
  output logic [31:0] write_ep_cnt_o
`endif
);

  localparam int AW = TCU_REG_ADDR_SIZE;
  localparam int DW = TCU_REG_DATA_SIZE;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_W0   = 3'd1,
    S_W1   = 3'd2,
    S_W2   = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       addr_q;
  logic [2:0][DW-1:0]  data_q;
  logic [2:0]          mask_q;

  logic                in_write;
  logic [1:0]          widx;
  logic                word_en;
  logic                advance;
  logic                start_any;
  logic [TCU_EP_SIZE-1:0] start_idx;
  logic [AW-1:0]       base;

  // unprivileged start wins when both paths fire together
  assign start_any = ep.write_ep_start_i | ep.write_ep_ext_start_i;
  assign start_idx = ep.write_ep_start_i ? ep.write_ep_epidx_i : ep.write_ep_ext_epidx_i;
  // computed in AW bits, so any overflow wraps modulo 2^AW
  assign base      = AW'(TCU_REGADDR_EP_START) + AW'(start_idx) * AW'(TCU_EP_REG_SIZE);

  always_comb begin
    in_write = 1'b0;
    widx     = 2'd0;
    case (state_q)
      S_W0: begin in_write = 1'b1; widx = 2'd0; end
      S_W1: begin in_write = 1'b1; widx = 2'd1; end
      S_W2: begin in_write = 1'b1; widx = 2'd2; end
      default: ;
    endcase
  end

  // stall only holds a word that is actually going to be written
  assign word_en = in_write & mask_q[widx];
  assign advance = in_write & ~(word_en & ep.write_ep_reg_stall_i);

  // state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_any) state_d = S_W0;
      S_W0:   if (advance)   state_d = S_W1;
      S_W1:   if (advance)   state_d = S_W2;
      S_W2:   if (advance)   state_d = S_FIN;
      S_FIN:                 state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // image latch and address walk; inputs are only looked at in the start cycle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else if (state_q == S_IDLE && start_any) begin
      addr_q <= base;
      data_q <= {ep.write_ep_data_2_i, ep.write_ep_data_1_i, ep.write_ep_data_0_i};
      mask_q <= ep.write_ep_mask_i;
    end else if (advance && widx != 2'd2) begin
      // address stays on word 2 after the last write
      addr_q <= addr_q + AW'(8);
    end
  end

  // outputs
  always_comb begin
    ep.write_ep_reg_en_o    = word_en & ~ep.write_ep_reg_stall_i;
    ep.write_ep_reg_addr_o  = addr_q;
    ep.write_ep_reg_wdata_o = in_write ? data_q[widx] : '0;
    ep.write_ep_active_o    = (state_q != S_IDLE);
    ep.write_ep_done_o      = (state_q == S_FIN);
  end

`ifdef TCU_WRITE_EP_CNT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i)
      write_ep_cnt_o <= '0;
    else if (state_q == S_FIN && write_ep_cnt_o != 32'hFFFF_FFFF)
      write_ep_cnt_o <= write_ep_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_tcu_ctrl_write_ep.sv
module tb_tcu_ctrl_write_ep;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tcu_ctrl_write_ep_if bus ();
`ifdef TCU_WRITE_EP_CNT_EN
  logic [31:0] cnt;
`endif

  tcu_ctrl_write_ep dut (
    .clk_i   (clk),
    .reset_i (rst),
    .ep      (bus)
`ifdef TCU_WRITE_EP_CNT_EN
    ,
    .write_ep_cnt_o (cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A job is a base address, three words, a mask and a position 0..3
  // (3 = the done cycle). Position moves on unless a masked word is stalled.
  bit          mdl_on = 1'b0;
  bit          m_busy = 1'b0;
  int          m_pos  = 0;
  logic [31:0] m_base;
  logic [63:0] m_w [3];
  logic [2:0]  m_mask;
  logic [31:0] m_cnt = '0;

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("en", {63'd0, bus.write_ep_reg_en_o},
          {63'd0, (m_busy && m_pos < 3 && m_mask[m_pos] && !bus.write_ep_reg_stall_i)});
      if (m_busy && m_pos < 3) begin
        chk("addr", {32'd0, bus.write_ep_reg_addr_o}, {32'd0, m_base + 32'(8 * m_pos)});
        chk("wdata", bus.write_ep_reg_wdata_o, m_w[m_pos]);
      end
      chk("active", {63'd0, bus.write_ep_active_o}, {63'd0, m_busy});
      chk("done", {63'd0, bus.write_ep_done_o}, {63'd0, (m_busy && m_pos == 3)});
`ifdef TCU_WRITE_EP_CNT_EN
      chk("cnt", {32'd0, cnt}, {32'd0, m_cnt});
`endif
      // advance to what the DUT holds after the coming edge
      if (rst) begin
        m_busy = 1'b0;
        m_cnt  = '0;
      end else if (!m_busy) begin
        if (bus.write_ep_start_i || bus.write_ep_ext_start_i) begin
          m_base = 32'h40 + 32'(bus.write_ep_start_i ? bus.write_ep_epidx_i
                                                     : bus.write_ep_ext_epidx_i) * 32'd24;
          m_w[0] = bus.write_ep_data_0_i;
          m_w[1] = bus.write_ep_data_1_i;
          m_w[2] = bus.write_ep_data_2_i;
          m_mask = bus.write_ep_mask_i;
          m_pos  = 0;
          m_busy = 1'b1;
        end
      end else if (m_pos == 3) begin
        m_busy = 1'b0;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else if (!(m_mask[m_pos] && bus.write_ep_reg_stall_i)) begin
        m_pos = m_pos + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input bit s, input bit e, input logic [15:0] idx, input logic [15:0] eidx,
                    input logic [2:0] m, input logic [63:0] d0, input logic [63:0] d1,
                    input logic [63:0] d2);
    bus.write_ep_start_i     = s;
    bus.write_ep_ext_start_i = e;
    bus.write_ep_epidx_i     = idx;
    bus.write_ep_ext_epidx_i = eidx;
    bus.write_ep_mask_i      = m;
    bus.write_ep_data_0_i    = d0;
    bus.write_ep_data_1_i    = d1;
    bus.write_ep_data_2_i    = d2;
  endtask

  task automatic clr();
    bus.write_ep_start_i     = 1'b0;
    bus.write_ep_ext_start_i = 1'b0;
  endtask

  task automatic lit(input string nm, input logic en, input logic [31:0] addr, input logic dn,
                     input logic act);
    chk({nm, "_en"}, {63'd0, bus.write_ep_reg_en_o}, {63'd0, en});
    chk({nm, "_addr"}, {32'd0, bus.write_ep_reg_addr_o}, {32'd0, addr});
    chk({nm, "_done"}, {63'd0, bus.write_ep_done_o}, {63'd0, dn});
    chk({nm, "_act"}, {63'd0, bus.write_ep_active_o}, {63'd0, act});
  endtask

  localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D3 = 64'h3333_3333_3333_3333;

  initial begin
    rst = 1'b1;
    bus.write_ep_reg_stall_i = 1'b0;
    go(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    mdl_on = 1'b1;
    @(negedge clk);
    lit("reset", 0, 32'h0, 0, 0);
    chk("reset_wdata", bus.write_ep_reg_wdata_o, 64'h0);
    step();
    rst = 1'b0;

    // T1: unprivileged, EP 2, full mask
    go(1, 0, 16'd2, 16'd7, 3'b111, D1, D2, D3);
    step(); clr();
    @(negedge clk); lit("t1_n1", 1, 32'h70, 0, 1); chk("t1_d0", bus.write_ep_reg_wdata_o, D1);
    step(); @(negedge clk); lit("t1_n2", 1, 32'h78, 0, 1); chk("t1_d1", bus.write_ep_reg_wdata_o, D2);
    step(); @(negedge clk); lit("t1_n3", 1, 32'h80, 0, 1); chk("t1_d2", bus.write_ep_reg_wdata_o, D3);
    step(); @(negedge clk); chk("t1_n4_done", {63'd0, bus.write_ep_done_o}, 64'd1);
    chk("t1_n4_en", {63'd0, bus.write_ep_reg_en_o}, 64'd0);
    step(); @(negedge clk); chk("t1_n5_act", {63'd0, bus.write_ep_active_o}, 64'd0);

    // T2: external, EP 0, mask 101
    go(0, 1, 16'd9, 16'd0, 3'b101, 64'hA, 64'hB, 64'hC);
    step(); clr();
    @(negedge clk); lit("t2_n1", 1, 32'h40, 0, 1); chk("t2_d0", bus.write_ep_reg_wdata_o, 64'hA);
    step(); @(negedge clk); chk("t2_n2_en", {63'd0, bus.write_ep_reg_en_o}, 64'd0);
    step(); @(negedge clk); lit("t2_n3", 1, 32'h50, 0, 1); chk("t2_d2", bus.write_ep_reg_wdata_o, 64'hC);
    step(); @(negedge clk); chk("t2_n4_done", {63'd0, bus.write_ep_done_o}, 64'd1);
    step();

    // T3: both starts, unprivileged EP 1 wins over external EP 5
    go(1, 1, 16'd1, 16'd5, 3'b001, D3, D2, D1);
    step(); clr();
    @(negedge clk); lit("t3_n1", 1, 32'h58, 0, 1);
    step(); step(); step();
    @(negedge clk); chk("t3_n4_done", {63'd0, bus.write_ep_done_o}, 64'd1);
    step();

    // T4: stall for two cycles on word 1 (EP 3 -> base 0x88)
    go(1, 0, 16'd3, 16'd0, 3'b111, D1, D2, D3);
    step(); clr();
    @(negedge clk); lit("t4_n1", 1, 32'h88, 0, 1);
    step(); bus.write_ep_reg_stall_i = 1'b1;
    @(negedge clk); lit("t4_n2", 0, 32'h90, 0, 1);
    step(); @(negedge clk); lit("t4_n3", 0, 32'h90, 0, 1); chk("t4_hold", bus.write_ep_reg_wdata_o, D2);
    step(); bus.write_ep_reg_stall_i = 1'b0;
    @(negedge clk); lit("t4_n4", 1, 32'h90, 0, 1); chk("t4_d1", bus.write_ep_reg_wdata_o, D2);
    step(); @(negedge clk); lit("t4_n5", 1, 32'h98, 0, 1);
    step(); @(negedge clk); chk("t4_n6_done", {63'd0, bus.write_ep_done_o}, 64'd1);
    step();
`ifdef TCU_WRITE_EP_CNT_EN
    @(negedge clk); chk("cnt_after4", {32'd0, cnt}, 64'd4);
`endif

    // T5: start while active is ignored; reset mid-sequence (EP 4 -> 0xA0)
    go(1, 0, 16'd4, 16'd0, 3'b111, D1, D2, D3);
    step(); clr();
    go(1, 1, 16'd6, 16'd6, 3'b111, D3, D3, D3);
    @(negedge clk); lit("t5_n1", 1, 32'hA0, 0, 1);
    step(); clr(); rst = 1'b1;
    @(negedge clk); lit("t5_n2", 1, 32'hA8, 0, 1);
    step(); rst = 1'b0;
    @(negedge clk); lit("t5_n3", 0, 32'h0, 0, 0);
`ifdef TCU_WRITE_EP_CNT_EN
    chk("cnt_reset", {32'd0, cnt}, 64'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      chk("t5_quiet_done", {63'd0, bus.write_ep_done_o}, 64'd0);
    end

    // random phase, checked by the model every cycle
    for (int i = 0; i < 1500; i++) begin
      step();
      go($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
         ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
         16'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
         {$urandom, $urandom});
      bus.write_ep_reg_stall_i = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 99) == 0);
    end
    step(); clr(); rst = 1'b0; bus.write_ep_reg_stall_i = 1'b0;
    repeat (10) step();
    @(negedge clk);
    mdl_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
